mitch_mult_pipe: RTL and testbench
==================================

// Module: mitch_mult_pipe
// PURPOSE
//  Parametrised, pipelined Mitchell logarithmic multiplier with W-bit mantissa truncation.
//  A per-operation mode bit selects an exact product instead of the approximation.
//  Valid/ready handshakes on input and output let it sit between streaming stages.
//  It supersedes the fixed 16-bit register-wrapped multiplier.
// PARAMETERS
//  N  16  operand width in bits (unsigned), N >= 4
//  W  6   mantissa bits kept after the leading one; 1 <= W <= N-1
// PORTS
//  clk        in   1    clock; all logic on posedge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    operand pair valid
//  in_ready   out  1    block accepts operands this cycle
//  x          in   N    operand X, unsigned
//  y          in   N    operand Y, unsigned
//  exact      in   1    1: P = x*y exactly; 0: Mitchell approximation
//  out_valid  out  1    p_out holds a result
//  out_ready  in   1    downstream accepts result
//  p_out      out  2N   product
// BEHAVIOUR
//  Reset (rst=1 at posedge): all stage valids clear, out_valid=0, p_out=0, stage data zeroed.
//  in_ready=0 while rst=1.
//  Pipeline advance enable: en = !out_valid | out_ready.
//  - in_ready = en & !rst.
//  - An input transfer occurs when in_valid & in_ready; x, y and exact are captured in S1.
//  - en=0 freezes every stage, including data and valids; no bubble collapsing.
//  Stages and latency:
//  - S1: capture inputs. S2: leading-one detect. S3: log add. S4: antilog, registered to p_out.
//  - 4 cycles from the transfer edge to out_valid=1 with no stall; throughput 1/cycle.
//  - Results leave in strict input order.
//  Output handshake:
//  - p_out and out_valid hold until out_valid & out_ready.
//  - The result is consumed on the same edge that loads the next one.
//  - Bubbles propagate as out_valid=0; p_out keeps its last value while out_valid=0.
//  Approx arithmetic (exact=0):
//  - k = index of leading one (0..N-1).
//  - m = bits below the leading one, left-aligned to W bits: m = ((a << (N-1-k)) >> (N-1-W)) mod 2^W.
//  - The LSBs of m are zero-filled when k < W; lower bits are truncated, never rounded.
//  - s = m1+m2, width W+1; K = k1+k2.
//  - If s < 2^W: P = ((2^W + s) << K) >> W.
//  - Otherwise:  P = (s << (K+1)) >> W.
//  - Intermediate width 2N+W+1; the final result is truncated to 2N bits.
//  Zero: x==0 or y==0 gives P=0 in both modes (zero flag carried down the pipe).
//  Exact (exact=1): P = x*y, full 2N bits, same latency; the mode bit travels with its data.
//  Simultaneous out_ready and a new in_valid on a full pipe: both transfers occur on that edge.
//  rst mid-operation: all in-flight results are discarded with no partial output.
//  - The first post-reset input appears 4 cycles after its transfer.
// TESTING
//  1 N=16,W=6: x=3,y=3,exact=0, out_ready=1 -> out_valid 4 cycles later, p_out=8.
//  2 x=4,y=5,exact=0 -> p_out=20; x=65535,y=65535,exact=0 -> p_out=32'hFC000000.
//  3 x=65535,y=65535,exact=1 -> p_out=32'hFFFE0001; x=0,y=1234, either mode -> p_out=0.
//  4 Stream 8 pairs back-to-back, out_ready=0 for cycles 6..9:
//    - in_ready=0 while stalled; no result lost or duplicated; order preserved.
//    - p_out stable during the stall.
//  5 rst=1 for 1 cycle with 3 ops in flight:
//    - next cycle out_valid=0, p_out=0; in_ready=0 during rst.
//    - a new op then completes after exactly 4 cycles.
//  6 Random x, y, exact with random out_ready:
//    - compare against a bit-accurate model of the formulas above.
//    - check the invariant out_valid & !out_ready => p_out unchanged next cycle.

Source files
------------

// File: rtl/mitch_mult_pipe_if.sv
// Operand/result stream bundle for the Mitchell multiplier: valid/ready on both sides.
// The slave modport is the multiplier's view; the master modport is the producer/consumer's view.
interface mitch_mult_pipe_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   x;
    logic [N-1:0]   y;
    logic           exact;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p_out;

    modport slave (
        input  in_valid, x, y, exact, out_ready,
        output in_ready, out_valid, p_out
    );

    modport master (
        output in_valid, x, y, exact, out_ready,
        input  in_ready, out_valid, p_out
    );
endinterface

// File: rtl/mitch_mult_pipe.sv
// Pipelined Mitchell log multiplier with an exact-mode bypass; result 4 edges after the transfer edge.
// Backpressure: a held result freezes the whole pipe and drops in_ready; nothing is lost or reordered.
module mitch_mult_pipe #(
    parameter int N = 16,
    parameter int W = 6
) (
    input  logic           clk,
    input  logic           rst,
    mitch_mult_pipe_if.slave bus
);
    localparam int KW = $clog2(N);
    localparam int IW = 2 * N + W + 1;
    localparam int PW = 2 * N;

    typedef struct packed {
        logic         vld;
        logic         ex;
        logic [N-1:0] x;
        logic [N-1:0] y;
    } s1_t;

    typedef struct packed {
        logic          vld;
        logic          ex;
        logic          zero;
        logic [KW-1:0] k1;
        logic [KW-1:0] k2;
        logic [W-1:0]  m1;
        logic [W-1:0]  m2;
        logic [N-1:0]  x;
        logic [N-1:0]  y;
    } s2_t;

    typedef struct packed {
        logic          vld;
        logic          ex;
        logic          zero;
        logic [KW:0]   ksum;
        logic [W:0]    msum;
        logic [PW-1:0] prod;
    } s3_t;

    function automatic logic [KW-1:0] lead_one(input logic [N-1:0] a);
        logic [KW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (a[i]) r = KW'(i);
        end
        return r;
    endfunction

    // Shift the leading one up to the MSB; the W bits just below it are the mantissa.
    function automatic logic [W-1:0] mant(input logic [N-1:0] a, input logic [KW-1:0] k);
        logic [KW-1:0] sh;
        logic [N-1:0]  norm;
        sh   = KW'(N - 1) - k;
        norm = a << sh;
        return norm[N-2 -: W];
    endfunction

    s1_t s1, s1_d;
    s2_t s2, s2_d;
    s3_t s3, s3_d;
    logic [PW-1:0] p_next;
    logic          en;

    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en && !rst;

    always_comb begin
        s1_d     = '0;
        s1_d.vld = bus.in_valid;
        s1_d.ex  = bus.exact;
        s1_d.x   = bus.x;
        s1_d.y   = bus.y;
    end

    always_comb begin
        s2_d      = '0;
        s2_d.vld  = s1.vld;
        s2_d.ex   = s1.ex;
        s2_d.zero = (s1.x == '0) || (s1.y == '0);
        s2_d.k1   = lead_one(s1.x);
        s2_d.k2   = lead_one(s1.y);
        s2_d.m1   = mant(s1.x, s2_d.k1);
        s2_d.m2   = mant(s1.y, s2_d.k2);
        s2_d.x    = s1.x;
        s2_d.y    = s1.y;
    end

    always_comb begin
        s3_d      = '0;
        s3_d.vld  = s2.vld;
        s3_d.ex   = s2.ex;
        s3_d.zero = s2.zero;
        s3_d.ksum = {1'b0, s2.k1} + {1'b0, s2.k2};
        s3_d.msum = {1'b0, s2.m1} + {1'b0, s2.m2};
        s3_d.prod = s2.x * s2.y;
    end

    // Antilog: a mantissa-sum carry means the implicit one is already in msum[W].
    always_comb begin
        p_next = '0;
        if (s3.zero) begin
            p_next = '0;
        end else if (s3.ex) begin
            p_next = s3.prod;
        end else if (s3.msum[W]) begin
            p_next = PW'((IW'(s3.msum) << (s3.ksum + 1'b1)) >> W);
        end else begin
            p_next = PW'((IW'({1'b1, s3.msum[W-1:0]}) << s3.ksum) >> W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= '0;
            s2            <= '0;
            s3            <= '0;
            bus.out_valid <= 1'b0;
            bus.p_out     <= '0;
        end else if (en) begin
            s1            <= s1_d;
            s2            <= s2_d;
            s3            <= s3_d;
            bus.out_valid <= s3.vld;
            if (s3.vld) bus.p_out <= p_next;
        end
    end
endmodule

// File: tb/tb_mitch_mult_pipe.sv
// Directed and random bench for mitch_mult_pipe; results are scored against a formula-level model.
module tb_mitch_mult_pipe;
    localparam int N = 16;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mitch_mult_pipe_if #(.N(N)) bus();

    mitch_mult_pipe #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    bit last_in;
    longint unsigned exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned model(input longint unsigned a, input longint unsigned b,
                                              input bit ex);
        longint unsigned ma, mb, s, p;
        int ka, kb, kk;
        if (a == 0 || b == 0) return 0;
        if (ex) return a * b;
        ka = 0;
        while ((a >> (ka + 1)) != 0) ka++;
        kb = 0;
        while ((b >> (kb + 1)) != 0) kb++;
        ma = ((a << (N - 1 - ka)) >> (N - 1 - W)) % (64'd1 << W);
        mb = ((b << (N - 1 - kb)) >> (N - 1 - W)) % (64'd1 << W);
        s  = ma + mb;
        kk = ka + kb;
        if (s < (64'd1 << W)) p = (((64'd1 << W) + s) << kk) >> W;
        else                  p = (s << (kk + 1)) >> W;
        return p & ((64'd1 << (2 * N)) - 1);
    endfunction

    // One clock: sample handshakes before the edge, score what happened after it.
    task automatic step();
        logic pre_rst, pre_in, pre_out, pre_hold, pre_vld;
        logic [2*N-1:0] pre_p;
        longint unsigned pre_m, got;
        #1;
        pre_rst  = rst;
        check("in_ready_rule", bus.in_ready, !rst && (!bus.out_valid || bus.out_ready));
        pre_in   = bus.in_valid & bus.in_ready;
        pre_out  = bus.out_valid & bus.out_ready;
        pre_hold = bus.out_valid & !bus.out_ready;
        pre_vld  = bus.out_valid;
        pre_p    = bus.p_out;
        pre_m    = pre_in ? model(bus.x, bus.y, bus.exact) : 0;
        @(posedge clk);
        #1;
        last_in = pre_in;
        if (pre_rst) begin
            exp_q.delete();
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_p_out", bus.p_out, 0);
        end else begin
            if (pre_out) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed output %0h expected no output", pre_p);
                end
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("result", pre_p, got);
                    n_out++;
                end
            end
            if (pre_hold) begin
                check("hold_p_out", bus.p_out, pre_p);
                check("hold_valid", bus.out_valid, 1);
            end
            if (!pre_vld && !bus.out_valid) check("bubble_p_out", bus.p_out, pre_p);
            if (pre_in) exp_q.push_back(pre_m);
        end
    endtask

    task automatic drain();
        int g = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && g < 50) begin
            step();
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
        step();
    endtask

    // Issue one op into an empty pipe; the transfer edge counts as edge 1.
    task automatic run_one(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input bit ex, input logic [2*N-1:0] expp);
        int lat;
        bus.in_valid  = 1'b1;
        bus.x         = a;
        bus.y         = b;
        bus.exact     = ex;
        bus.out_ready = 1'b1;
        step();
        check({tag, "_accepted"}, last_in, 1);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check({tag, "_p_out"}, bus.p_out, expp);
        step();
    endtask

    initial begin
        logic [N-1:0] xs[8];
        logic [N-1:0] ys[8];
        int idx, c, base;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.exact     = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_p_out", bus.p_out, 0);

        run_one("t1_3x3", 16'd3, 16'd3, 1'b0, 32'd8);
        run_one("t2_4x5", 16'd4, 16'd5, 1'b0, 32'd20);
        run_one("t2_max_approx", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFC000000);
        run_one("t3_max_exact", 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001);
        run_one("t3_zero_approx", 16'd0, 16'd1234, 1'b0, 32'd0);
        run_one("t3_zero_exact", 16'd0, 16'd1234, 1'b1, 32'd0);
        run_one("small_exact", 16'd7, 16'd9, 1'b1, 32'd63);

        for (int i = 0; i < 8; i++) begin
            xs[i] = N'($urandom_range(1, 65535));
            ys[i] = N'($urandom_range(1, 65535));
        end
        base = n_out;
        idx  = 0;
        c    = 0;
        while (idx < 8 && c < 40) begin
            bus.in_valid  = 1'b1;
            bus.x         = xs[idx];
            bus.y         = ys[idx];
            bus.exact     = idx[0];
            bus.out_ready = !(c >= 6 && c <= 9);
            #1;
            if (c >= 6 && c <= 9) check("stall_in_ready", bus.in_ready, 0);
            step();
            if (last_in) idx++;
            c++;
        end
        check("stream_all_issued", idx, 8);
        drain();
        check("stream_out_count", n_out - base, 8);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.x        = N'(i + 3);
            bus.y        = N'(i + 11);
            bus.exact    = 1'b0;
            step();
        end
        rst = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("post_rst_q_empty", exp_q.size(), 0);
        run_one("t5_after_rst", 16'd100, 16'd200, 1'b0, 32'(model(100, 200, 1'b0)));

        for (int i = 0; i < 400; i++) begin
            int r;
            bus.in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            bus.x = (r == 0) ? '0 : (r == 1) ? '1 : (r < 5) ? N'($urandom_range(1, 15)) : N'($urandom);
            r = $urandom_range(0, 9);
            bus.y = (r == 0) ? '0 : (r == 1) ? '1 : (r < 5) ? N'($urandom_range(1, 15)) : N'($urandom);
            bus.exact     = $urandom_range(0, 1) != 0;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
